// File: rtl/serv_wb_arbiter.sv
// Two-master (ibus read-only, dbus read/write) to one-slave classic Wishbone arbiter.
// Optional watchdog built only when SERV_ARB_TIMEOUT_EN is defined.
module serv_wb_arbiter #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state;
  logic   gnt_i_c;
  logic   gnt_d_c;
  logic   req_c;
  logic   wd_fire_c;
  logic   ack_c;

  if (TIMEOUT_W < 2) begin : g_bad_timeout_w
    $error("serv_wb_arbiter: TIMEOUT_W must be at least 2");
  end

  assign gnt_i_c = (state == GNT_I) && i_ibus_cyc;
  assign gnt_d_c = (state == GNT_D) && i_dbus_cyc;
  assign req_c   = gnt_i_c || gnt_d_c;
  assign ack_c   = req_c && (i_wb_ack || wd_fire_c);

`ifdef SERV_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 timeout_q;

  // Watchdog: held at zero while idle so every grant starts a fresh count.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wd_cnt <= '0;
      end else if (o_wb_cyc && !i_wb_ack) begin
        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
      end
      if (wd_fire_c) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // A real slave ack in the terminal cycle wins over the watchdog.
  assign wd_fire_c = req_c && (wd_cnt == '1) && !i_wb_ack;
  assign o_timeout = timeout_q;
`else
  assign wd_fire_c = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Grant FSM; every release passes through IDLE so a stale cyc is never re-granted.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_dbus_cyc) begin
            state <= GNT_D;
          end else if (i_ibus_cyc) begin
            state <= GNT_I;
          end
        end
        GNT_I: begin
          if (!i_ibus_cyc || ack_c) begin
            state <= IDLE;
          end
        end
        GNT_D: begin
          if (!i_dbus_cyc || ack_c) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave request mux and zero-latency ack/read-data return.
  always_comb begin
    o_wb_adr   = '0;
    o_wb_dat   = '0;
    o_wb_sel   = '0;
    o_wb_we    = 1'b0;
    o_wb_cyc   = req_c && !wd_fire_c;
    o_ibus_ack = gnt_i_c && (i_wb_ack || wd_fire_c);
    o_dbus_ack = gnt_d_c && (i_wb_ack || wd_fire_c);
    o_ibus_rdt = '0;
    o_dbus_rdt = '0;
    case (state)
      GNT_I: begin
        o_wb_adr = i_ibus_adr;
        o_wb_sel = 4'hF;
        if (!wd_fire_c) begin
          o_ibus_rdt = i_wb_rdt;
        end
      end
      GNT_D: begin
        o_wb_adr = i_dbus_adr;
        o_wb_dat = i_dbus_dat;
        o_wb_sel = i_dbus_sel;
        o_wb_we  = i_dbus_we;
        if (!wd_fire_c) begin
          o_dbus_rdt = i_wb_rdt;
        end
      end
      default: ;
    endcase
  end

endmodule
